lbp: RTL and testbench



---
 rtl/lbp_pkg.sv | 19 +
 rtl/lbp_code.sv | 15 +
 rtl/lbp.sv | 182 ++++++++++++++++++
 tb/tb_lbp.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lbp_pkg.sv
// rtl/lbp_pkg.sv - shared constants, FSM states and 3x3 window indexing for the LBP engine
package lbp_pkg;

    localparam int IMG_W  = 128;
    localparam int ADDR_W = 14;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Window slot = row*3 + col; slot 4 is the centre, the rest map to code bits 0..7.
    localparam int CTR_IDX = 4;
    localparam int NB_WIN_IDX [8] = '{0, 1, 2, 3, 5, 6, 7, 8};

endpackage

// File: rtl/lbp_code.sv
// rtl/lbp_code.sv - combinational LBP code: bit k set when neighbour k >= centre
module lbp_code (
    input  logic [7:0]      ctr_i,
    input  logic [7:0][7:0] nbr_i,
    output logic [7:0]      code_o
);

    always_comb begin
        code_o = '0;
        for (int k = 0; k < 8; k++) begin
            code_o[k] = (nbr_i[k] >= ctr_i);
        end
    end

endmodule

// File: rtl/lbp.sv
// rtl/lbp.sv - LBP engine: sliding 3x3 window over the gray image, one code per interior pixel
module lbp
    import lbp_pkg::*;
#(
    parameter int IMG_W  = lbp_pkg::IMG_W,
    parameter int ADDR_W = lbp_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gray_ready,
    output logic [ADDR_W-1:0] gray_addr,
    output logic              gray_req,
    input  logic [7:0]        gray_data,
    output logic [ADDR_W-1:0] lbp_addr,
    output logic              lbp_valid,
    output logic [7:0]        lbp_data,
    output logic              finish
);

    localparam int            CW       = ADDR_W / 2;
    localparam logic [CW-1:0] LAST_CTR = CW'(IMG_W - 2);

    state_e              state_q, state_d;
    logic [CW-1:0]       row_q, row_d, col_q, col_d;
    logic [1:0]          rd_row_q, rd_row_d, rd_col_q, rd_col_d;
    logic [ADDR_W-1:0]   gray_addr_q, gray_addr_d;
    logic                gray_req_q, gray_req_d;
    logic [ADDR_W-1:0]   lbp_addr_q, lbp_addr_d;
    logic                lbp_valid_q, lbp_valid_d;
    logic [7:0]          lbp_data_q, lbp_data_d;
    logic                shift_win;
    logic [3:0]          slot;
    logic [7:0]          win_q [9];
    logic [7:0][7:0]     nbr;
    logic [7:0]          code;

    // Image width is a power of two, so row-major address is just {row, col}.
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [CW-1:0] row, input logic [CW-1:0] col,
                                                   input logic [1:0] dr, input logic [1:0] dc);
        logic [CW-1:0] r;
        logic [CW-1:0] c;
        r = row - CW'(1) + CW'(dr);
        c = col - CW'(1) + CW'(dc);
        return {r, c};
    endfunction

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            nbr[k] = win_q[NB_WIN_IDX[k]];
        end
    end

    lbp_code u_code (
        .ctr_i  (win_q[CTR_IDX]),
        .nbr_i  (nbr),
        .code_o (code)
    );

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        rd_row_d    = rd_row_q;
        rd_col_d    = rd_col_q;
        gray_addr_d = gray_addr_q;
        gray_req_d  = 1'b0;
        lbp_addr_d  = lbp_addr_q;
        lbp_valid_d = 1'b0;
        lbp_data_d  = lbp_data_q;
        shift_win   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gray_ready) begin
                    state_d     = ST_READ;
                    row_d       = CW'(1);
                    col_d       = CW'(1);
                    rd_row_d    = 2'd0;
                    rd_col_d    = 2'd0;
                    gray_req_d  = 1'b1;
                    gray_addr_d = pix_addr(row_d, col_d, 2'd0, 2'd0);
                end
            end
            ST_READ: begin
                if (rd_row_q == 2'd2 && rd_col_q == 2'd2) begin
                    state_d = ST_WAIT;
                end else begin
                    if (rd_row_q == 2'd2) begin
                        rd_row_d = 2'd0;
                        rd_col_d = rd_col_q + 2'd1;
                    end else begin
                        rd_row_d = rd_row_q + 2'd1;
                    end
                    gray_req_d  = 1'b1;
                    gray_addr_d = pix_addr(row_q, col_q, rd_row_d, rd_col_d);
                end
            end
            ST_WAIT: begin
                state_d     = ST_WRITE;
                lbp_valid_d = 1'b1;
                lbp_addr_d  = {row_q, col_q};
                lbp_data_d  = code;
            end
            ST_WRITE: begin
                if (row_q == LAST_CTR && col_q == LAST_CTR) begin
                    state_d = ST_DONE;
                end else begin
                    state_d  = ST_READ;
                    rd_row_d = 2'd0;
                    if (col_q == LAST_CTR) begin
                        row_d    = row_q + CW'(1);
                        col_d    = CW'(1);
                        rd_col_d = 2'd0;
                    end else begin
                        // Same row: keep two columns, fetch only the new right column.
                        col_d     = col_q + CW'(1);
                        rd_col_d  = 2'd2;
                        shift_win = 1'b1;
                    end
                    gray_req_d  = 1'b1;
                    gray_addr_d = pix_addr(row_d, col_d, 2'd0, rd_col_d);
                end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            rd_row_q    <= '0;
            rd_col_q    <= '0;
            gray_addr_q <= '0;
            gray_req_q  <= 1'b0;
            lbp_addr_q  <= '0;
            lbp_valid_q <= 1'b0;
            lbp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            rd_row_q    <= rd_row_d;
            rd_col_q    <= rd_col_d;
            gray_addr_q <= gray_addr_d;
            gray_req_q  <= gray_req_d;
            lbp_addr_q  <= lbp_addr_d;
            lbp_valid_q <= lbp_valid_d;
            lbp_data_q  <= lbp_data_d;
        end
    end

    // The read counters travel with gray_addr, so they name the slot of the datum arriving now.
    assign slot = 4'(rd_row_q) * 4'd3 + 4'(rd_col_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            if (shift_win) begin
                for (int rr = 0; rr < 3; rr++) begin
                    win_q[rr*3]     <= win_q[rr*3+1];
                    win_q[rr*3+1]   <= win_q[rr*3+2];
                end
            end
            if (gray_req_q) begin
                win_q[slot] <= gray_data;
            end
        end
    end

    assign gray_addr = gray_addr_q;
    assign gray_req  = gray_req_q;
    assign lbp_addr  = lbp_addr_q;
    assign lbp_valid = lbp_valid_q;
    assign lbp_data  = lbp_data_q;
    assign finish    = (state_q == ST_DONE);

endmodule

// File: tb/tb_lbp.sv
// tb/tb_lbp.sv - self-checking bench for lbp on a reduced 32x32 image
module tb_lbp;

    localparam int IMG_W  = 32;
    localparam int ADDR_W = 10;
    localparam int NPIX   = IMG_W * IMG_W;
    localparam int NINT   = (IMG_W - 2) * (IMG_W - 2);

    logic              clk = 1'b0;
    logic              reset;
    logic              gray_ready;
    logic [ADDR_W-1:0] gray_addr;
    logic              gray_req;
    logic [7:0]        gray_data = 8'd0;
    logic [ADDR_W-1:0] lbp_addr;
    logic              lbp_valid;
    logic [7:0]        lbp_data;
    logic              finish;

    always #5 clk = ~clk;

    lbp #(.IMG_W(IMG_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .gray_ready (gray_ready),
        .gray_addr  (gray_addr),
        .gray_req   (gray_req),
        .gray_data  (gray_data),
        .lbp_addr   (lbp_addr),
        .lbp_valid  (lbp_valid),
        .lbp_data   (lbp_data),
        .finish     (finish)
    );

    logic [7:0] gmem [NPIX];
    logic [7:0] rmem [NPIX];
    int pulses;
    int border_hits;
    int total;
    int bad;

    function automatic bit is_border(input int a);
        int r;
        int c;
        r = a / IMG_W;
        c = a % IMG_W;
        return (r == 0 || c == 0 || r == IMG_W - 1 || c == IMG_W - 1);
    endfunction

    always @(negedge clk) begin
        if (gray_req) gray_data = gmem[gray_addr];
        if (lbp_valid) begin
            rmem[lbp_addr] = lbp_data;
            pulses++;
            if (is_border(int'(lbp_addr))) border_hits++;
        end
    end

    function automatic logic [7:0] ref_code(input int r, input int c);
        int dr [8];
        int dc [8];
        logic [7:0] code;
        if (r == 0 || c == 0 || r == IMG_W - 1 || c == IMG_W - 1) return 8'h00;
        dr = '{-1, -1, -1, 0, 0, 1, 1, 1};
        dc = '{-1, 0, 1, -1, 1, -1, 0, 1};
        code = 8'h00;
        for (int k = 0; k < 8; k++) begin
            code[k] = (gmem[(r + dr[k]) * IMG_W + c + dc[k]] >= gmem[r * IMG_W + c]);
        end
        return code;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_mem(input string name);
        int nbad;
        int first;
        nbad  = 0;
        first = 0;
        for (int i = 0; i < NPIX; i++) begin
            if (rmem[i] !== ref_code(i / IMG_W, i % IMG_W)) begin
                if (nbad == 0) first = i;
                nbad++;
            end
        end
        total++;
        if (nbad != 0) begin
            bad++;
            $display("FAIL %s: %0d words differ, first addr %0d got %02h want %02h",
                     name, nbad, first, rmem[first], ref_code(first / IMG_W, first % IMG_W));
        end
    endtask

    task automatic load_pattern(input int pat);
        for (int i = 0; i < NPIX; i++) begin
            int r;
            int c;
            r = i / IMG_W;
            c = i % IMG_W;
            case (pat)
                0:       gmem[i] = 8'd50;
                1:       gmem[i] = 8'(c);
                2:       gmem[i] = (r == 10 && c == 10) ? 8'd0 : 8'd100;
                3:       gmem[i] = 8'($urandom_range(0, 255));
                default: gmem[i] = 8'($urandom_range(0, 3));
            endcase
        end
    endtask

    task automatic clear_results();
        for (int i = 0; i < NPIX; i++) rmem[i] = 8'h00;
        pulses      = 0;
        border_hits = 0;
    endtask

    task automatic apply_reset();
        reset      = 1'b0;
        gray_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_finish(input string name);
        int n;
        n = 0;
        while (!finish && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(finish), 64'd1);
    endtask

    typedef struct {
        int         pat;
        int         r;
        int         c;
        logic [7:0] exp;
    } vec_t;

    vec_t vt [$];

    initial begin
        int viol;
        int n;
        int p_snap;
        total = 0;
        bad   = 0;

        vt.push_back('{0, 1, 1, 8'hFF});
        vt.push_back('{0, 30, 30, 8'hFF});
        vt.push_back('{0, 0, 5, 8'h00});
        vt.push_back('{0, 31, 31, 8'h00});
        vt.push_back('{1, 1, 1, 8'hD6});
        vt.push_back('{1, 15, 30, 8'hD6});
        vt.push_back('{1, 7, 0, 8'h00});
        vt.push_back('{2, 10, 10, 8'hFF});
        vt.push_back('{2, 9, 9, 8'h7F});
        vt.push_back('{2, 11, 11, 8'hFE});
        vt.push_back('{2, 9, 10, 8'hBF});
        vt.push_back('{2, 10, 11, 8'hF7});
        vt.push_back('{2, 5, 20, 8'hFF});

        // Reset state, idle hold with gray_ready low, then a random image.
        load_pattern(3);
        clear_results();
        reset      = 1'b0;
        gray_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", {gray_addr, gray_req, lbp_addr, lbp_valid, lbp_data, finish}, 64'd0);
        reset = 1'b1;
        viol  = 0;
        repeat (50) begin
            @(negedge clk);
            if (gray_req || lbp_valid || finish) viol++;
        end
        check("idle_hold", 64'(viol), 64'd0);
        gray_ready = 1'b1;
        @(negedge clk);
        check("start_req", 64'(gray_req), 64'd1);
        check("first_addr", 64'(gray_addr), 64'd0);
        gray_ready = 1'b0;
        wait_finish("finish_random");
        check_mem("mem_random");
        check("pulses_random", 64'(pulses), 64'(NINT));
        check("border_random", 64'(border_hits), 64'd0);
        p_snap = pulses;
        repeat (20) @(negedge clk);
        check("finish_hold", 64'(finish), 64'd1);
        check("no_extra_pulses", 64'(pulses), 64'(p_snap));
        check("req_in_done", 64'(gray_req), 64'd0);

        // Fixed patterns with table probes.
        for (int pat = 0; pat < 3; pat++) begin
            load_pattern(pat);
            clear_results();
            apply_reset();
            gray_ready = 1'b1;
            wait_finish($sformatf("finish_pat%0d", pat));
            gray_ready = 1'b0;
            check_mem($sformatf("mem_pat%0d", pat));
            check($sformatf("pulses_pat%0d", pat), 64'(pulses), 64'(NINT));
            check($sformatf("border_pat%0d", pat), 64'(border_hits), 64'd0);
            foreach (vt[i]) begin
                if (vt[i].pat == pat)
                    check($sformatf("probe_p%0d_r%0d_c%0d", pat, vt[i].r, vt[i].c),
                          64'(rmem[vt[i].r * IMG_W + vt[i].c]), 64'(vt[i].exp));
            end
        end

        // Asynchronous reset in the middle of row 20, then full reprocess.
        load_pattern(4);
        clear_results();
        apply_reset();
        gray_ready = 1'b1;
        n = 0;
        while (!(lbp_valid && (int'(lbp_addr) / IMG_W) == 20) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check("reached_row20", 64'(n < 20000), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", {gray_addr, gray_req, lbp_addr, lbp_valid, lbp_data, finish}, 64'd0);
        @(negedge clk);
        pulses      = 0;
        border_hits = 0;
        reset       = 1'b1;
        wait_finish("finish_after_abort");
        gray_ready = 1'b0;
        check_mem("mem_after_abort");
        check("pulses_after_abort", 64'(pulses), 64'(NINT));
        check("border_after_abort", 64'(border_hits), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
